// File: rtl/fmc_rd_ram_map_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : fmc_pkg                                                        |
// | Brief   : Shared widths, state encoding and helpers for the FMC read map |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
package fmc_pkg;

  localparam int FMC_ADDR_W = 25;
  localparam int FMC_DATA_W = 16;

  // Value returned for reads that fall outside the status bank.
  localparam logic [FMC_DATA_W-1:0] ADDR_ERR_DATA = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRIVE   = 2'd2
  } fmc_state_e;

  // Bus strobes are active-low; a read is NE low, NOE low, NWE high.
  function automatic logic fmc_is_read(input logic cs_n, input logic rd_n,
                                       input logic wr_n);
    return !cs_n && !rd_n && wr_n;
  endfunction

endpackage : fmc_pkg
`default_nettype wire

// File: rtl/fmc_rd_ram_map_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : fmc_sync                                                        |
// | Brief  : N-stage synchronizer for an active-low async strobe, resets to 1|
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module fmc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  assign sync_d = {sync_q[STAGES-2:0], d_i};

  // Reset to 1 so the bus looks idle until real strobes propagate through.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : fmc_sync
`default_nettype wire

// File: rtl/fmc_rd_ram_map.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : fmc_rd_ram_map                                                  |
// | Brief  : FMC async-SRAM read responder over a bank of FPGA status words  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module fmc_rd_ram_map
  import fmc_pkg::*;
#(
  parameter int NREG        = 64,
  parameter int ADDR_W      = FMC_ADDR_W,
  parameter int DATA_W      = FMC_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cs_i,
  input  logic                     rd_i,
  input  logic                     wr_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [NREG*DATA_W-1:0]   fpga_arm_data_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     data_oe_o,
  output logic                     rd_done_o,
  output logic [ADDR_W-1:0]        rd_addr_o,
  output logic                     addr_err_o
);

  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [ADDR_W:0] NREG_EXT = (ADDR_W+1)'(NREG);

  logic cs_s;
  logic rd_s;
  logic wr_s;

  fmc_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (cs_i),
    .q_o   (cs_s)
  );

  fmc_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rd_i),
    .q_o   (rd_s)
  );

  fmc_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (wr_i),
    .q_o   (wr_s)
  );

  logic [DATA_W-1:0] word_w [NREG];

  for (genvar k = 0; k < NREG; k++) begin : g_words
    assign word_w[k] = fpga_arm_data_i[k*DATA_W +: DATA_W];
  end

  fmc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              oe_q, oe_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              err_q, err_d;
  logic              rd_req_q;

  logic              rd_req_w;
  logic              rd_start_w;
  logic              in_range_w;
  logic [DATA_W-1:0] word_sel_w;

  // Only a fresh rising edge of the read condition starts a transfer, so a
  // strobe still held low after an exit cannot retrigger.
  assign rd_req_w   = fmc_is_read(cs_s, rd_s, wr_s);
  assign rd_start_w = rd_req_w && !rd_req_q;
  assign in_range_w = ({1'b0, addr_q} < NREG_EXT);
  assign word_sel_w = word_w[addr_q[IDX_W-1:0]];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    oe_d      = oe_q;
    done_d    = 1'b0;
    rd_addr_d = rd_addr_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_start_w) begin
          addr_d  = addr_i;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (in_range_w) begin
          data_d = word_sel_w;
        end else begin
          data_d = DATA_W'(ADDR_ERR_DATA);
          err_d  = 1'b1;
        end
        oe_d    = 1'b1;
        state_d = DRIVE;
      end
      DRIVE: begin
        // A write strobe during the drive phase aborts without completion.
        if (!wr_s) begin
          oe_d    = 1'b0;
          state_d = IDLE;
        end else if (rd_s || cs_s) begin
          oe_d      = 1'b0;
          done_d    = 1'b1;
          rd_addr_d = addr_q;
          state_d   = IDLE;
        end
      end
      default: begin
        oe_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      oe_q      <= 1'b0;
      done_q    <= 1'b0;
      rd_addr_q <= '0;
      err_q     <= 1'b0;
      rd_req_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      oe_q      <= oe_d;
      done_q    <= done_d;
      rd_addr_q <= rd_addr_d;
      err_q     <= err_d;
      rd_req_q  <= rd_req_w;
    end
  end

  assign data_o     = data_q;
  assign data_oe_o  = oe_q;
  assign rd_done_o  = done_q;
  assign rd_addr_o  = rd_addr_q;
  assign addr_err_o = err_q;

endmodule : fmc_rd_ram_map
`default_nettype wire

// File: tb/tb_fmc_rd_ram_map.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_fmc_rd_ram_map                                               |
// | Brief  : Self-checking bench for the FMC read responder                  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_fmc_rd_ram_map;

  localparam int NREG = 64;
  localparam int AW   = 25;
  localparam int DW   = 16;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              cs_i  = 1'b1;
  logic              rd_i  = 1'b1;
  logic              wr_i  = 1'b1;
  logic [AW-1:0]     addr_i = '0;
  logic [NREG*DW-1:0] flat = '0;
  logic [DW-1:0]     data_o;
  logic              data_oe_o;
  logic              rd_done_o;
  logic [AW-1:0]     rd_addr_o;
  logic              addr_err_o;

  fmc_rd_ram_map #(
    .NREG        (NREG),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .cs_i            (cs_i),
    .rd_i            (rd_i),
    .wr_i            (wr_i),
    .addr_i          (addr_i),
    .fpga_arm_data_i (flat),
    .data_o          (data_o),
    .data_oe_o       (data_oe_o),
    .rd_done_o       (rd_done_o),
    .rd_addr_o       (rd_addr_o),
    .addr_err_o      (addr_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference contents of the status bank.
  logic [DW-1:0] words [NREG];

  int n_chk  = 0;
  int n_pass = 0;

  bit            chk_en   = 1'b0;
  logic          exp_oe   = 1'b0;
  logic          exp_done = 1'b0;
  logic          exp_err  = 1'b0;
  logic [DW-1:0] exp_data = '0;
  logic [AW-1:0] exp_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("oe", 32'(data_oe_o), 32'(exp_oe));
      check("rd_done", 32'(rd_done_o), 32'(exp_done));
      check("addr_err", 32'(addr_err_o), 32'(exp_err));
      if (exp_oe) check("data", 32'(data_o), 32'(exp_data));
      if (exp_done) check("rd_addr", 32'(rd_addr_o), 32'(exp_addr));
    end
  end

  task automatic push_words();
    for (int k = 0; k < NREG; k++) flat[k*DW +: DW] = words[k];
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // NOE falls now; the word is visible on the 4th edge, captured as it was
  // when the read began, with an error pulse for out-of-range addresses.
  task automatic start_read(input logic [AW-1:0] a, input bit use_lit, input logic [DW-1:0] lit);
    logic [DW-1:0] snap;
    bit oor;
    oor  = (a >= AW'(NREG));
    snap = oor ? 16'h0000 : words[int'(a)];
    addr_i = a;
    cs_i = 1'b0; rd_i = 1'b0; wr_i = 1'b1;
    repeat (3) step();
    step();
    exp_oe = 1'b1; exp_data = snap; exp_err = oor;
    if (use_lit) begin
      @(negedge clk_i);
      check("lit_data", 32'(data_o), 32'(lit));
    end
    step();
    exp_err = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold, input int endmode,
                         input bit chg, input logic [DW-1:0] newval,
                         input bit use_lit, input logic [DW-1:0] lit);
    start_read(a, use_lit, lit);
    for (int i = 0; i < hold; i++) begin
      if (chg && i == 0 && a < AW'(NREG)) begin
        words[int'(a)] = newval;
        push_words();
      end
      step();
    end
    if (endmode == 0) rd_i = 1'b1;
    else if (endmode == 1) cs_i = 1'b1;
    else begin rd_i = 1'b1; cs_i = 1'b1; end
    step(); step();
    step();
    exp_oe = 1'b0; exp_done = 1'b1; exp_addr = a;
    if (use_lit) begin
      @(negedge clk_i);
      check("lit_rd_addr", 32'(rd_addr_o), 32'(a));
    end
    step();
    exp_done = 1'b0;
    cs_i = 1'b1; rd_i = 1'b1;
    addr_i = AW'($urandom);
    repeat ($urandom_range(1, 3)) step();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input int len);
    addr_i = a;
    cs_i = 1'b0; wr_i = 1'b0; rd_i = 1'b1;
    repeat (len) step();
    cs_i = 1'b1; wr_i = 1'b1;
    repeat (3) step();
  endtask

  task automatic do_abort(input logic [AW-1:0] a, input int hold);
    start_read(a, 1'b0, 16'h0000);
    repeat (hold) step();
    wr_i = 1'b0;
    step(); step();
    step();
    exp_oe = 1'b0;
    step();
    cs_i = 1'b1; rd_i = 1'b1;
    step(); step();
    wr_i = 1'b1;
    repeat (2) step();
  endtask

  logic [AW-1:0] ra;
  int            sel;

  initial begin
    for (int k = 0; k < NREG; k++) words[k] = DW'($urandom);
    push_words();

    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_data", 32'(data_o), 32'h0);
    check("rst_oe", 32'(data_oe_o), 32'h0);
    check("rst_done", 32'(rd_done_o), 32'h0);
    check("rst_rd_addr", 32'(rd_addr_o), 32'h0);
    check("rst_err", 32'(addr_err_o), 32'h0);
    step();
    rst_i = 1'b0;
    chk_en = 1'b1;
    repeat (2) step();

    // Snapshot survives a live update; the next read sees the new value.
    words[5] = 16'hA55A;
    push_words();
    do_read(25'd5, 4, 0, 1'b1, 16'h1234, 1'b1, 16'hA55A);
    do_read(25'd5, 2, 1, 1'b0, 16'h0000, 1'b1, 16'h1234);

    // First address past the bank reads as zero and flags an error.
    do_read(25'd64, 2, 0, 1'b0, 16'h0000, 1'b1, 16'h0000);

    do_write(25'd3, 6);
    do_abort(25'd9, 2);

    // Reset mid-drive: output enable drops without waiting for a clock.
    start_read(25'd7, 1'b0, 16'h0000);
    step();
    #2;
    rst_i = 1'b1;
    #1;
    check("async_oe", 32'(data_oe_o), 32'h0);
    check("async_done", 32'(rd_done_o), 32'h0);
    exp_oe = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    cs_i = 1'b1; rd_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
    step(); step();
    words[0] = 16'h00FF;
    push_words();
    do_read(25'd0, 1, 2, 1'b0, 16'h0000, 1'b1, 16'h00FF);

    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 7);
      if (sel == 0) ra = AW'(NREG + $urandom_range(0, 100));
      else if (sel == 1) ra = '1;
      else ra = AW'($urandom_range(0, NREG - 1));
      if ($urandom_range(0, 3) == 0) begin
        words[$urandom_range(0, NREG - 1)] = DW'($urandom);
        push_words();
      end
      case ($urandom_range(0, 9))
        0: do_write(ra, $urandom_range(2, 6));
        1: do_abort(ra, $urandom_range(0, 4));
        default: do_read(ra, $urandom_range(1, 6), $urandom_range(0, 2),
                         1'($urandom), DW'($urandom), 1'b0, 16'h0000);
      endcase
    end

    repeat (4) step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_fmc_rd_ram_map
`default_nettype wire

// File: doc/fmc_rd_ram_map.md
Name: fmc_rd_ram_map

Overview:
- FPGA→ARM read responder on the FMC/FSMC async SRAM-style bus. It is the read-side counterpart of the ARM→FPGA write register map.
- Detects an ARM read cycle (NE low, NOE low, NWE high) and decodes the address against a bank of NREG 16-bit FPGA status words.
- Snapshots the selected word and drives it onto the shared data bus with an output enable.
- Emits a one-cycle read-done strobe with the address, so clear-on-read flags and FIFO pops can be implemented downstream.

Parameters:
- NREG, 64, number of readable 16-bit words (addresses 0..NREG-1)
- ADDR_W, 25, FMC address width
- DATA_W, 16, FMC data width
- SYNC_STAGES, 2, flip-flop stages on the async strobes cs_i/rd_i/wr_i (minimum 2)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- cs_i  in  1  FMC chip select NE, active-low, asynchronous to clk_i
- rd_i  in  1  FMC output enable NOE, active-low, asynchronous
- wr_i  in  1  FMC write enable NWE, active-low, asynchronous
- addr_i  in  ADDR_W  FMC address, stable while NOE low
- fpga_arm_data_i  in  NREG*DATA_W  flattened status words; word k = bits [k*16+15 : k*16]
- data_o  out  DATA_W  read data toward the bidirectional pad
- data_oe_o  out  1  1 = FPGA drives the data bus
- rd_done_o  out  1  one-cycle pulse at the end of a completed read
- rd_addr_o  out  ADDR_W  address of the read that completed; valid while rd_done_o=1
- addr_err_o  out  1  one-cycle pulse when a read targets an address >= NREG

Behaviour:
- Reset values: data_o=0, data_oe_o=0, rd_done_o=0, rd_addr_o=0, addr_err_o=0. Synchronizers are set to 1 (bus idle). FSM is in IDLE.
- Strobes pass through SYNC_STAGES flops: cs_s, rd_s, wr_s. The read condition is rd_req = !cs_s & !rd_s & wr_s.
- IDLE: on rd_req go to CAPTURE and register addr_i into addr_q. addr_i is sampled directly; its setup is covered by the synchronizer delay.
- CAPTURE (1 cycle):
  - If addr_q < NREG: data_o <= word[addr_q].
  - Else: data_o <= 0 and addr_err_o pulses.
  - Go to DRIVE.
- DRIVE: data_oe_o=1 and data_o holds the snapshot. Live changes on fpga_arm_data_i are ignored until the next read.
  - Normal exit: when rd_s=1 or cs_s=1, set data_oe_o=0 and pulse rd_done_o with rd_addr_o=addr_q, then go to IDLE.
  - Protocol-violation exit: if wr_s=0 while in DRIVE, set data_oe_o=0 with no rd_done_o, then go to IDLE.
- Latency: with SYNC_STAGES=2, data_oe_o rises 4 clk_i edges after NOE falls. The ARM FMC DATAST must cover at least SYNC_STAGES+2 clk periods plus pad delay.
- data_oe_o falls SYNC_STAGES+1 cycles after NOE rises. The ARM bus-turnaround time (BUSTURN) must exceed this.
- Back-to-back reads: a new read needs at least one IDLE cycle with rd_req=0 after rd_done_o. rd_req still low at exit does not re-trigger; the FSM waits in IDLE for a fresh rd_req edge.
- Writes (!cs_s & !wr_s) are ignored in every state except as the abort condition in DRIVE.
- An async reset mid-read drops data_oe_o immediately and returns the FSM to IDLE with no rd_done_o.
- The address comparison is unsigned and full ADDR_W width. There is no wrap or aliasing: address NREG+k is out of range, not word k.

Decomposition:
- Package fmc_pkg holds:
  - FMC_ADDR_W = 25, FMC_DATA_W = 16
  - FSM state enum {IDLE, CAPTURE, DRIVE}
  - ADDR_ERR_DATA = 16'h0000
- One sub-module, fmc_sync (parameterised N-stage synchronizer with reset value 1), instantiated for cs_i, rd_i and wr_i.

Test Plan:
- Word 5 = 16'hA55A; read addr 5 → data_oe_o=1 at the 4th edge after NOE falls, data_o=16'hA55A; after NOE rises, one rd_done_o pulse with rd_addr_o=5.
- Word 5 changes to 16'h1234 during DRIVE → data_o stays 16'hA55A until the read ends; the next read of addr 5 returns 16'h1234.
- Read addr 64 with NREG=64 → data_o=0, addr_err_o pulses once, rd_done_o pulses with rd_addr_o=64.
- Write cycle to addr 3 (NE=0, NWE=0, NOE=1) → data_oe_o stays 0, no rd_done_o.
- NWE driven low during DRIVE → data_oe_o drops within SYNC_STAGES+1 cycles, no rd_done_o.
- rst_i asserted mid-DRIVE → data_oe_o=0 asynchronously; after release, a read of addr 0 with word 0 = 16'h00FF returns 16'h00FF.
